// File: rtl/clk_nco_bank.sv
// clk_nco_bank: CHANNELS phase-accumulator clock enables on refclk with lock report; define CLK_NCO_SHADOW_EN for wrap-aligned incr updates.
// Latency: ce_out is the registered accumulator carry (1 cycle); accepted config writes are visible from the next edge.
// Backpressure: cfg_ready drops for a channel while its deferred incr waits for a wrap (shadow build only; otherwise always 1).
module clk_nco_bank #(
  parameter int CHANNELS      = 5,
  parameter int ACC_W         = 32,
  parameter int SETTLE_CYCLES = 16,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [ACC_W-1:0]    cfg_incr,
  input  logic [ACC_W-1:0]    cfg_phase,
  input  logic                run,
  output logic [CHANNELS-1:0] ce_out,
  output logic                locked
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [ACC_W-1:0]    acc   [CHANNELS];
  logic [ACC_W-1:0]    incr  [CHANNELS];
  logic [ACC_W-1:0]    phase [CHANNELS];
  logic [ACC_W-1:0]    sum   [CHANNELS];
  logic [CHANNELS-1:0] carry, chan_hit, wr_sel;
  logic                active, reenter, any_pending;

  // Accumulators advance only when the bank is out of IDLE and stays out.
  assign active = run && (state != IDLE);

  always_comb begin
    carry    = '0;
    chan_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      {carry[i], sum[i]} = {1'b0, acc[i]} + {1'b0, incr[i]};
      chan_hit[i]        = (cfg_chan == CW'(i));
    end
  end

`ifdef CLK_NCO_SHADOW_EN
  logic [ACC_W-1:0]    shadow_incr [CHANNELS];
  logic [CHANNELS-1:0] pending, apply, direct;

  // A stopped channel (incr = 0) has no wrap to wait for, so it takes updates at once.
  always_comb begin
    cfg_ready = 1'b1;
    apply     = '0;
    direct    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan_hit[i] && pending[i]) cfg_ready = 1'b0;
      direct[i] = !active || (incr[i] == '0);
      apply[i]  = pending[i] && (!run || (active && carry[i]));
    end
    wr_sel  = (cfg_valid && cfg_ready) ? chan_hit : '0;
    reenter = active && ((|apply) || (|(wr_sel & direct)));
  end

  assign any_pending = |pending;
`else
  assign cfg_ready   = 1'b1;
  assign wr_sel      = cfg_valid ? chan_hit : '0;
  assign reenter     = active && (|wr_sel);
  assign any_pending = 1'b0;
`endif

  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    locked    = (state == RUN);
    case (state)
      IDLE: begin
        if (run) begin
          state_nxt = SETTLE;
          cnt_nxt   = CNT_INIT;
        end
      end
      SETTLE: begin
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        else if (!any_pending) state_nxt = RUN;
      end
      RUN:     ;
      default: state_nxt = IDLE;
    endcase
    if (reenter) begin
      state_nxt = SETTLE;
      cnt_nxt   = CNT_INIT;
    end
    if (!run) state_nxt = IDLE;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      ce_out <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i]   <= '0;
        incr[i]  <= '0;
        phase[i] <= '0;
`ifdef CLK_NCO_SHADOW_EN
        shadow_incr[i] <= '0;
`endif
      end
`ifdef CLK_NCO_SHADOW_EN
      pending <= '0;
`endif
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        ce_out[i] <= active && carry[i];
        if (state == IDLE && run) acc[i] <= phase[i];
        else if (active)          acc[i] <= sum[i];
        if (wr_sel[i]) phase[i] <= cfg_phase;
`ifdef CLK_NCO_SHADOW_EN
        // Swapping incr on the wrap edge keeps every period whole.
        if (apply[i]) begin
          incr[i]    <= shadow_incr[i];
          pending[i] <= 1'b0;
        end else if (wr_sel[i]) begin
          if (direct[i]) begin
            incr[i] <= cfg_incr;
          end else begin
            shadow_incr[i] <= cfg_incr;
            pending[i]     <= 1'b1;
          end
        end
`else
        if (wr_sel[i]) incr[i] <= cfg_incr;
`endif
      end
    end
  end

endmodule

// File: tb/tb_clk_nco_bank.sv
// Scoreboard bench for clk_nco_bank (ACC_W = 8, CHANNELS = 5, SETTLE_CYCLES = 16).
// Expected ce_out/locked come from a closed-form phase model pushed per edge and compared on the falling edge.
module tb_clk_nco_bank;
  localparam int     CH  = 5;
  localparam int     W   = 8;
  localparam int     SC  = 16;
  localparam int     CW  = 3;
  localparam longint MOD = 256;

  logic          refclk    = 1'b0;
  logic          rst       = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          run       = 1'b0;
  logic [CW-1:0] cfg_chan  = '0;
  logic [W-1:0]  cfg_incr  = '0;
  logic [W-1:0]  cfg_phase = '0;
  logic          cfg_ready, locked;
  logic [CH-1:0] ce_out;

  clk_nco_bank #(.CHANNELS(CH), .ACC_W(W), .SETTLE_CYCLES(SC)) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_incr(cfg_incr), .cfg_phase(cfg_phase),
    .run(run), .ce_out(ce_out), .locked(locked)
  );

  always #5 refclk = ~refclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [CH-1:0] ce;
    logic          lk;
  } exp_t;
  exp_t exp_q[$];

  // Reference state: each channel's accumulator is base + k*inc since edge t0.
  longint m_base[CH], m_inc[CH], m_t0[CH], m_phase[CH], m_shadow[CH];
  bit     m_pend[CH];
  bit     m_on   = 1'b0;
  bit     m_reen = 1'b0;
  longint lock_at = 0;
  longint cyc     = 0;

  function automatic bit carry_at(longint base, longint inc, longint k);
    return ((base + k * inc) / MOD) != ((base + (k - 1) * inc) / MOD);
  endfunction

  function automatic bit exp_ready(logic [CW-1:0] ch);
    return (int'(ch) < CH) ? !m_pend[int'(ch)] : 1'b1;
  endfunction

  task automatic rebase(int ch, longint ni);
    m_base[ch] = (m_base[ch] + (cyc - m_t0[ch]) * m_inc[ch]) % MOD;
    m_t0[ch]   = cyc;
    m_inc[ch]  = ni;
  endtask

  task automatic mdl_write(int ch, bit act);
    m_phase[ch] = longint'(cfg_phase);
`ifdef CLK_NCO_SHADOW_EN
    if (act && m_inc[ch] != 0) begin
      m_shadow[ch] = longint'(cfg_incr);
      m_pend[ch]   = 1'b1;
      return;
    end
`endif
    if (act) begin
      rebase(ch, longint'(cfg_incr));
      m_reen = 1'b1;
    end else begin
      m_inc[ch] = longint'(cfg_incr);
    end
  endtask

  task automatic step();
    logic [CH-1:0] e;
    bit            wr;
    int            wch;
    @(posedge refclk);
    cyc++;
    e      = '0;
    m_reen = 1'b0;
    wch    = int'(cfg_chan);
    wr     = cfg_valid && exp_ready(cfg_chan) && (wch < CH);
    if (rst) begin
      m_on = 1'b0;
      for (int i = 0; i < CH; i++) begin
        m_inc[i] = 0; m_phase[i] = 0; m_shadow[i] = 0;
        m_base[i] = 0; m_t0[i] = 0; m_pend[i] = 1'b0;
      end
    end else if (!run) begin
      m_on = 1'b0;
      for (int i = 0; i < CH; i++) begin
        if (m_pend[i]) begin
          m_inc[i]  = m_shadow[i];
          m_pend[i] = 1'b0;
        end
      end
      if (wr) mdl_write(wch, 1'b0);
    end else if (!m_on) begin
      m_on    = 1'b1;
      lock_at = cyc + SC;
      for (int i = 0; i < CH; i++) begin
        m_t0[i]   = cyc;
        m_base[i] = m_phase[i];
      end
      if (wr) mdl_write(wch, 1'b0);
    end else begin
      for (int i = 0; i < CH; i++) begin
        e[i] = carry_at(m_base[i], m_inc[i], cyc - m_t0[i]);
        if (e[i] && m_pend[i]) begin
          rebase(i, m_shadow[i]);
          m_pend[i] = 1'b0;
          m_reen    = 1'b1;
        end
      end
      if (wr) mdl_write(wch, 1'b1);
    end
    if (m_reen) lock_at = cyc + SC;
    exp_q.push_back({e, m_on && (cyc >= lock_at)});
    #1;
  endtask

  task automatic cfg_wr(int ch, int inc, int ph);
    cfg_valid = 1'b1;
    cfg_chan  = CW'(ch);
    cfg_incr  = W'(inc);
    cfg_phase = W'(ph);
    step();
    cfg_valid = 1'b0;
  endtask

  exp_t   mon_e;
  longint mcyc     = 0;
  longint last0    = -1000;
  longint min_gap0 = 1000;

  always @(negedge refclk) begin
    mcyc++;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("ce_out", ce_out, mon_e.ce);
      chk("locked", locked, mon_e.lk);
    end
    if (ce_out[0] === 1'b1) begin
      if (mcyc - last0 < min_gap0) min_gap0 = mcyc - last0;
      last0 = mcyc;
    end
  end

  initial begin
    int first0, first1, cnt2, cnt3, prev, gap;

    rst = 1'b1;
    step();
    chk("rst_ready", cfg_ready, 1);
    step();
    rst = 1'b0;
    step();

    cfg_wr(0, 64, 0);
    cfg_wr(1, 64, 128);
    cfg_wr(2, 0, 77);
    cfg_wr(3, 255, 0);
    cfg_wr(4, 3, 200);

    // Bring-up: step i shows outputs after edge N+i, N being the edge that samples run.
    run = 1'b1;
    first0 = -1; first1 = -1; cnt2 = 0; cnt3 = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 15) chk("lock_early", locked, 0);
      if (i == 16) chk("lock_rise", locked, 1);
      if (first0 < 0 && ce_out[0] === 1'b1) first0 = i;
      if (first1 < 0 && ce_out[1] === 1'b1) first1 = i;
      if (i >= 20 && i < 276) begin
        cnt2 += int'(ce_out[2]);
        cnt3 += int'(ce_out[3]);
      end
    end
    chk("ch0_first", first0, 4);
    chk("ch1_first", first1, 2);
    chk("ch2_none", cnt2, 0);
    chk("ch3_255of256", cnt3, 255);

    // Rate change on ch0 made between strobes.
    for (int i = 0; i < 8 && ce_out[0] !== 1'b1; i++) step();
    chk("ch0_strobe_seen", ce_out[0], 1);
    step();
    cfg_wr(0, 32, 0);
    cfg_chan = '0;
    #1;
    chk("ready_after_wr", cfg_ready, exp_ready(3'd0));
    prev = -1; gap = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      chk("ready_track", cfg_ready, exp_ready(3'd0));
      if (ce_out[0] === 1'b1) begin
        if (prev >= 0) gap = i - prev;
        prev = i;
      end
    end
    chk("ch0_new_period", gap, 8);
    for (int i = 0; i < 20; i++) step();

    // Out-of-range channel: accepted and ignored.
    cfg_valid = 1'b1;
    cfg_chan  = CW'(CH);
    cfg_incr  = 8'd99;
    cfg_phase = 8'd99;
    #1;
    chk("oor_ready", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    for (int i = 0; i < 10; i++) step();
    chk("oor_locked", locked, 1);

    // Stop and restart: accumulators reload from phase.
    run = 1'b0;
    step();
    chk("stop_unlock", locked, 0);
    for (int i = 0; i < 3; i++) step();
    run = 1'b1;
    for (int i = 0; i < 30; i++) step();

    // Reset mid-run.
    rst = 1'b1;
    step();
    chk("rst_ce", ce_out, 0);
    chk("rst_lock", locked, 0);
    chk("rst_ready2", cfg_ready, 1);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();

    @(negedge refclk);
    #1;
    chk("sb_drain", exp_q.size(), 0);
    chk("ch0_min_gap", min_gap0 >= 4, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
